// File: rtl/spi_dev_pkg.sv
// Shared types and constants for the SPI device-side byte engine.
package spi_dev_pkg;

  localparam int ByteW = 8;

  // Byte shifted out when the front-end has not supplied a tx byte in time.
  localparam logic [ByteW-1:0] TxFillDefault = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

endpackage

// File: rtl/spi_dev_sck_edge.sv
// Brings the asynchronous SPI pins into the clk_i domain and turns sck
// transitions into single-cycle sample/shift strobes according to cpol/cpha.
// csb is synchronised alongside so its edges line up with the sck strobes.
module spi_dev_sck_edge #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpol_i,
  input  logic cpha_i,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sdi_i,
  output logic sample_o,
  output logic shift_o,
  output logic sdi_o,
  output logic csb_fall_o,
  output logic csb_rise_o
);

  logic [SyncStages-1:0] sck_sync_q;
  logic [SyncStages-1:0] csb_sync_q;
  logic [SyncStages-1:0] sdi_sync_q;
  logic                  sck_prev_q;
  logic                  csb_prev_q;
  logic                  sck_s;
  logic                  csb_s;
  logic                  sck_rise;
  logic                  sck_fall;

  // Synchroniser chains plus one extra stage on sck/csb for edge detection.
  // csb resets high so leaving reset never looks like a select.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q <= '0;
      csb_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SyncStages-2:0], sck_i};
      csb_sync_q <= {csb_sync_q[SyncStages-2:0], csb_i};
      sdi_sync_q <= {sdi_sync_q[SyncStages-2:0], sdi_i};
      sck_prev_q <= sck_sync_q[SyncStages-1];
      csb_prev_q <= csb_sync_q[SyncStages-1];
    end
  end

  assign sck_s    = sck_sync_q[SyncStages-1];
  assign csb_s    = csb_sync_q[SyncStages-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Sampling happens on the rising edge exactly when cpol and cpha agree
  // (modes 0 and 3); the opposite edge is the shift edge.
  assign sample_o   = (cpol_i == cpha_i) ? sck_rise : sck_fall;
  assign shift_o    = (cpol_i == cpha_i) ? sck_fall : sck_rise;
  assign sdi_o      = sdi_sync_q[SyncStages-1];
  assign csb_fall_o = csb_prev_q & ~csb_s;
  assign csb_rise_o = ~csb_prev_q & csb_s;

endmodule

// File: rtl/spi_dev_byte_engine.sv
// SPI target byte engine: oversampled SPI pins, MSB-first byte shifting,
// one-entry rx and tx holding registers with valid/ready handshakes.
// Optional debug counter enabled by defining SPI_DEV_BYTE_ENGINE_DEBUG_EN.
module spi_dev_byte_engine
  import spi_dev_pkg::*;
#(
  parameter int               SyncStages = 2,
  parameter logic [ByteW-1:0] TxFill     = TxFillDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic             spi_sck_i,
  input  logic             spi_csb_i,
  input  logic             spi_sdi_i,
  output logic             spi_sdo_o,
  output logic             spi_sdo_en_o,
  output logic [ByteW-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_overflow_o,
  input  logic [ByteW-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             tx_underflow_o,
  output logic             active_o
`ifdef SPI_DEV_BYTE_ENGINE_DEBUG_EN
  ,
  output logic [15:0]      sck_pulses_o
`endif
);

  logic sample_w, shift_w, sdi_w, csb_fall_w, csb_rise_w;

  spi_dev_sck_edge #(.SyncStages(SyncStages)) u_sck_edge (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .sck_i      (spi_sck_i),
    .csb_i      (spi_csb_i),
    .sdi_i      (spi_sdi_i),
    .sample_o   (sample_w),
    .shift_o    (shift_w),
    .sdi_o      (sdi_w),
    .csb_fall_o (csb_fall_w),
    .csb_rise_o (csb_rise_w)
  );

  state_e           state_q;
  logic [ByteW-1:0] shift_tx_q;
  logic [ByteW-2:0] shift_rx_q;
  logic [2:0]       bit_cnt_q;
  logic             first_q;     // no sample edge seen yet since LOAD
  logic             sdo_q, sdo_en_q;
  logic [ByteW-1:0] tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;
  logic             tx_underflow_q, tx_underflow_d;
  logic [ByteW-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overflow_q, rx_overflow_d;

  logic             in_shift, sample_evt, shift_evt, byte_done, load_evt;
  logic [ByteW-1:0] rx_byte, tx_byte;

  // csb rise outranks any sck edge detected in the same cycle.
  assign in_shift   = (state_q == StShift);
  assign sample_evt = in_shift & sample_w & ~csb_rise_w;
  assign shift_evt  = in_shift & shift_w & ~csb_rise_w;
  assign byte_done  = sample_evt & (bit_cnt_q == 3'd7);
  assign rx_byte    = {shift_rx_q, sdi_w};
  // A new tx byte is fetched in LOAD and on the first shift edge after each
  // completed byte; the first shift edge of a cpha=1 transfer is not one.
  assign load_evt   = ((state_q == StLoad) & ~csb_rise_w) |
                      (shift_evt & (bit_cnt_q == 3'd0) & ~first_q);
  assign tx_byte    = tx_full_q ? tx_hold_q : TxFill;

  // Next state of the rx/tx holding registers and their status pulses.
  always_comb begin
    tx_hold_d      = tx_hold_q;
    tx_full_d      = tx_full_q;
    tx_underflow_d = load_evt & ~tx_full_q;
    if (load_evt && tx_full_q) tx_full_d = 1'b0;
    if (tx_valid_i && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_hold_d = tx_data_i;
    end
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overflow_d = 1'b0;
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        rx_overflow_d = 1'b1;
      end
    end
  end

  // Holding registers; reset empties both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_hold_q      <= '0;
      tx_full_q      <= 1'b0;
      tx_underflow_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overflow_q  <= 1'b0;
    end else begin
      tx_hold_q      <= tx_hold_d;
      tx_full_q      <= tx_full_d;
      tx_underflow_q <= tx_underflow_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_overflow_q  <= rx_overflow_d;
    end
  end

  // Transfer FSM with registered sdo/sdo_en and the two shift registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= 3'd0;
      first_q    <= 1'b0;
      sdo_q      <= 1'b0;
      sdo_en_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          sdo_q     <= 1'b0;
          sdo_en_q  <= 1'b0;
          bit_cnt_q <= 3'd0;
          if (csb_fall_w) state_q <= StLoad;
        end
        StLoad: begin
          if (csb_rise_w) begin
            state_q <= StIdle;
          end else begin
            shift_tx_q <= tx_byte;
            sdo_q      <= tx_byte[ByteW-1];
            sdo_en_q   <= 1'b1;
            first_q    <= 1'b1;
            bit_cnt_q  <= 3'd0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (csb_rise_w) begin
            state_q   <= StIdle;
            sdo_q     <= 1'b0;
            sdo_en_q  <= 1'b0;
            bit_cnt_q <= 3'd0;
          end else begin
            if (sample_w) begin
              shift_rx_q <= {shift_rx_q[ByteW-3:0], sdi_w};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              first_q    <= 1'b0;
            end
            if (shift_w) begin
              if (first_q) begin
                sdo_q <= shift_tx_q[ByteW-1];
              end else if (bit_cnt_q == 3'd0) begin
                shift_tx_q <= tx_byte;
                sdo_q      <= tx_byte[ByteW-1];
              end else begin
                sdo_q      <= shift_tx_q[ByteW-2];
                shift_tx_q <= {shift_tx_q[ByteW-2:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SPI_DEV_BYTE_ENGINE_DEBUG_EN
  logic [15:0] sck_pulses_q;

  // Saturating count of sample edges since the last select; held after deselect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_pulses_q <= '0;
    end else if (state_q == StLoad) begin
      sck_pulses_q <= '0;
    end else if (sample_evt && (sck_pulses_q != 16'hFFFF)) begin
      sck_pulses_q <= sck_pulses_q + 16'd1;
    end
  end

  assign sck_pulses_o = sck_pulses_q;
`endif

  assign spi_sdo_o      = sdo_q;
  assign spi_sdo_en_o   = sdo_en_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overflow_o  = rx_overflow_q;
  assign tx_ready_o     = ~tx_full_q;
  assign tx_underflow_o = tx_underflow_q;
  assign active_o       = in_shift;

endmodule

// File: tb/tb_spi_dev_byte_engine.sv
// Bench for spi_dev_byte_engine: bit-banged SPI host, tx feeder, rx/pulse
// monitor, a vector table, hand-written corner sequences and a randomized
// run against a transfer-level reference model.
module tb_spi_dev_byte_engine;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk_i = 1'b0;
  logic       rst_i, cpol_i, cpha_i, spi_sck_i, spi_csb_i, spi_sdi_i;
  logic       spi_sdo_o, spi_sdo_en_o, rx_valid_o, rx_ready_i, rx_overflow_o;
  logic [7:0] rx_data_o, tx_data_i;
  logic       tx_valid_i, tx_ready_o, tx_underflow_o, active_o;
`ifdef SPI_DEV_BYTE_ENGINE_DEBUG_EN
  logic [15:0] sck_pulses_o;
`endif

  always #5 clk_i = ~clk_i;

  spi_dev_byte_engine dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpol_i         (cpol_i),
    .cpha_i         (cpha_i),
    .spi_sck_i      (spi_sck_i),
    .spi_csb_i      (spi_csb_i),
    .spi_sdi_i      (spi_sdi_i),
    .spi_sdo_o      (spi_sdo_o),
    .spi_sdo_en_o   (spi_sdo_en_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .rx_overflow_o  (rx_overflow_o),
    .tx_data_i      (tx_data_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .tx_underflow_o (tx_underflow_o),
    .active_o       (active_o)
`ifdef SPI_DEV_BYTE_ENGINE_DEBUG_EN
    ,
    .sck_pulses_o   (sck_pulses_o)
`endif
  );

  int         n_tests = 0;
  int         n_fail = 0;
  int         unf_cnt = 0;
  int         ovf_cnt = 0;
  logic [7:0] feed_q[$];    // bytes the feeder still has to offer
  logic [7:0] tx_model[$];  // bytes the engine will transmit, in order
  logic [7:0] rx_got[$];    // bytes popped from the rx port

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Offers queued tx bytes; a byte leaves the queue once the handshake
  // (valid and ready seen before the edge) has completed.
  initial begin
    logic rdy, val, rst_s;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      rdy = tx_ready_o; val = tx_valid_i; rst_s = rst_i;
      @(posedge clk_i);
      #1;
      if (val && rdy && !rst_s && feed_q.size() > 0) void'(feed_q.pop_front());
      tx_valid_i = (feed_q.size() > 0);
      if (feed_q.size() > 0) tx_data_i = feed_q[0];
    end
  end

  // Collects popped rx bytes and counts the one-cycle status pulses.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
        if (rx_overflow_o) ovf_cnt++;
        if (tx_underflow_o) unf_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Host side: selects, clocks nbits MSB-first from d[31:..], captures sdo
  // on the sample edge, optionally leaves csb asserted.
  task automatic host_xfer(input bit pol, input bit pha, input logic [31:0] d,
                           input int nbits, input bit keep, output logic [31:0] cap);
    cap = '0;
    cpol_i = pol; cpha_i = pha; spi_sck_i = pol;
    spi_sdi_i = d[31];
    tick(H);
    spi_csb_i = 1'b0;
    tick(2 * H);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        spi_sdi_i = d[31-i];
        tick(H);
        cap = {cap[30:0], spi_sdo_o};
        spi_sck_i = ~pol;
        tick(H);
        spi_sck_i = pol;
      end else begin
        tick(H);
        spi_sck_i = ~pol;
        spi_sdi_i = d[31-i];
        tick(H);
        cap = {cap[30:0], spi_sdo_o};
        spi_sck_i = pol;
      end
    end
    tick(H);
    if (!keep) begin
      spi_csb_i = 1'b1;
      tick(3 * H);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sdo"}, spi_sdo_o, 0);
    check({tag, "_sdo_en"}, spi_sdo_en_o, 0);
    check({tag, "_rx_data"}, rx_data_o, 0);
    check({tag, "_rx_valid"}, rx_valid_o, 0);
    check({tag, "_rx_ovf"}, rx_overflow_o, 0);
    check({tag, "_tx_ready"}, tx_ready_o, 1);
    check({tag, "_tx_unf"}, tx_underflow_o, 0);
    check({tag, "_active"}, active_o, 0);
  endtask

  typedef struct {
    bit          pol;
    bit          pha;
    logic [31:0] host;
    int          nbits;
    int          ntx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    logic [31:0] exp_cap;
    int          nrx;
    logic [31:0] exp_rx;
    int          exp_unf;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [31:0] cap;
    int          u0, o0;

    // A cpha=0 transfer also fetches a byte on the shift edge after its
    // last byte, hence one extra underflow when nothing is queued.
    tbl[0] = '{1'b0, 1'b0, 32'hA500_0000,  8, 1, 8'h3C, 8'h00, 32'h3C,   1, 32'hA5,   1};
    tbl[1] = '{1'b1, 1'b1, 32'h1234_0000, 16, 2, 8'hC0, 8'hDE, 32'hC0DE, 2, 32'h1234, 0};
    tbl[2] = '{1'b0, 1'b1, 32'h7781_0000, 16, 0, 8'h00, 8'h00, 32'hFFFF, 2, 32'h7781, 2};
    tbl[3] = '{1'b1, 1'b0, 32'h9600_0000,  8, 1, 8'h69, 8'h00, 32'h69,   1, 32'h96,   1};

    rst_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0;
    spi_sck_i = 1'b0; spi_csb_i = 1'b1; spi_sdi_i = 1'b0; rx_ready_i = 1'b1;
    tick(4);
    check_reset_vals("reset");
    rst_i = 1'b0;
    tick(4);

    // Vector table
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].ntx > 0) feed_q.push_back(tbl[v].tx0);
      if (tbl[v].ntx > 1) feed_q.push_back(tbl[v].tx1);
      tick(6);
      rx_got.delete(); u0 = unf_cnt; o0 = ovf_cnt;
      host_xfer(tbl[v].pol, tbl[v].pha, tbl[v].host, tbl[v].nbits, 1'b0, cap);
      $display("[TB] vec %0d mode %0d host %h sdo %h rx %0d bytes", v,
               {tbl[v].pol, tbl[v].pha}, tbl[v].host, cap, rx_got.size());
      check($sformatf("vec%0d_cap", v), cap, tbl[v].exp_cap);
      check($sformatf("vec%0d_nrx", v), rx_got.size(), tbl[v].nrx);
      for (int k = 0; k < tbl[v].nrx && k < rx_got.size(); k++)
        check($sformatf("vec%0d_rx%0d", v, k), rx_got[k],
              tbl[v].exp_rx[8*(tbl[v].nrx-1-k) +: 8]);
      check($sformatf("vec%0d_unf", v), unf_cnt - u0, tbl[v].exp_unf);
      check($sformatf("vec%0d_ovf", v), ovf_cnt - o0, 0);
      check($sformatf("vec%0d_tx_ready", v), tx_ready_o, 1);
    end

    // Overflow: three bytes with nobody popping keeps only the first
    rx_ready_i = 1'b0; rx_got.delete(); o0 = ovf_cnt;
    host_xfer(1'b0, 1'b0, 32'h0102_0300, 24, 1'b0, cap);
    $display("[TB] overflow xfer sdo %h rx_data %h", cap, rx_data_o);
    check("ovf_cap", cap, 32'hFF_FFFF);
    check("ovf_rx_valid", rx_valid_o, 1);
    check("ovf_rx_data", rx_data_o, 8'h01);
    check("ovf_pulses", ovf_cnt - o0, 2);
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    tick(2);
    check("ovf_pop_valid", rx_valid_o, 0);
    check("ovf_pop_count", rx_got.size(), 1);
    if (rx_got.size() > 0) check("ovf_pop_data", rx_got[0], 8'h01);

    // Deselect after 5 bits, then a clean byte must be aligned
    rx_ready_i = 1'b1; rx_got.delete();
    host_xfer(1'b0, 1'b0, 32'hB800_0000, 5, 1'b0, cap);
    $display("[TB] abort xfer 5 bits sdo %h", cap);
    check("abort_cap", cap, 32'h1F);
    check("abort_rx_valid", rx_valid_o, 0);
    check("abort_nrx", rx_got.size(), 0);
    host_xfer(1'b0, 1'b0, 32'h5A00_0000, 8, 1'b0, cap);
    $display("[TB] post-abort xfer rx %0d bytes", rx_got.size());
    check("realign_nrx", rx_got.size(), 1);
    if (rx_got.size() > 0) check("realign_rx", rx_got[0], 8'h5A);

    // Reset in the middle of the second byte with both holding regs full
    rx_ready_i = 1'b0; rx_got.delete();
    feed_q.push_back(8'h11); feed_q.push_back(8'h22); feed_q.push_back(8'h33);
    tick(6);
    host_xfer(1'b0, 1'b0, 32'hA7E0_0000, 11, 1'b1, cap);
    check("pre_rst_active", active_o, 1);
    check("pre_rst_rx_valid", rx_valid_o, 1);
    check("pre_rst_tx_ready", tx_ready_o, 0);
    rst_i = 1'b1;
    tick(2);
    check_reset_vals("rst_mid");
    spi_csb_i = 1'b1; spi_sck_i = 1'b0;
    tick(4);
    rst_i = 1'b0;
    tick(4 * H);
    check_reset_vals("post_rst");
    rx_ready_i = 1'b1; rx_got.delete();
    feed_q.push_back(8'h44);
    tick(6);
    host_xfer(1'b0, 1'b0, 32'hC300_0000, 8, 1'b0, cap);
    $display("[TB] post-reset xfer sdo %h rx %0d bytes", cap, rx_got.size());
    check("post_rst_cap", cap, 32'h44);
    check("post_rst_nrx", rx_got.size(), 1);
    if (rx_got.size() > 0) check("post_rst_rx", rx_got[0], 8'hC3);

    // Randomized transfers against the transfer-level model
    tx_model.delete();
    for (int t = 0; t < 24; t++) begin
      bit          pol, pha;
      int          nbits, ntx, slots, exp_unf;
      logic [31:0] d, exp_cap;
      logic [63:0] stream;
      logic [7:0]  b;
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 8 * $urandom_range(1, 3);
      d = $urandom;
      ntx = $urandom_range(0, 3);
      for (int k = 0; k < ntx; k++) begin
        b = 8'($urandom);
        feed_q.push_back(b);
        tx_model.push_back(b);
      end
      tick(8);
      // Bytes fetched: one at select, then one per completed byte that is
      // followed by a shift edge.
      slots = pha ? (nbits + 7) / 8 : 1 + nbits / 8;
      stream = '0; exp_unf = 0;
      for (int s = 0; s < slots; s++) begin
        if (tx_model.size() > 0) begin
          b = tx_model.pop_front();
        end else begin
          b = 8'hFF;
          exp_unf++;
        end
        stream = {stream[55:0], b};
      end
      exp_cap = 32'(stream >> (slots * 8 - nbits));
      rx_got.delete(); u0 = unf_cnt; o0 = ovf_cnt;
      host_xfer(pol, pha, d, nbits, 1'b0, cap);
      $display("[TB] rand %0d mode %0d bits %0d host %h sdo %h", t, {pol, pha}, nbits, d, cap);
      check($sformatf("rand%0d_cap", t), cap, exp_cap);
      check($sformatf("rand%0d_nrx", t), rx_got.size(), nbits / 8);
      for (int k = 0; k < nbits / 8 && k < rx_got.size(); k++)
        check($sformatf("rand%0d_rx%0d", t, k), rx_got[k], d[31-8*k -: 8]);
      check($sformatf("rand%0d_unf", t), unf_cnt - u0, exp_unf);
      check($sformatf("rand%0d_ovf", t), ovf_cnt - o0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_dev_byte_engine.md
Name: spi_dev_byte_engine

Overview:
Synthesizable SPI device-side (target) byte engine: the responding end of the host/device SPI link that the DV spi agent drives and monitors. It oversamples sck/csb/sdi in the system clock domain and deserialises host data into bytes. It serialises response bytes onto sdo. Byte-level valid/ready ports connect to a device front-end (e.g. FIFO or register-file bridge).

Parameters:
SyncStages, 2, synchroniser depth on spi_sck_i/spi_csb_i/spi_sdi_i (min 2)
TxFill, 8'hFF, byte shifted out when no tx byte is available (underflow)

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
cpol_i  input  1  clock polarity; static while csb low
cpha_i  input  1  clock phase; static while csb low
spi_sck_i  input  1  SPI clock from host (async)
spi_csb_i  input  1  chip select, active low (async)
spi_sdi_i  input  1  host-to-device serial data (host's sdo)
spi_sdo_o  output  1  device-to-host serial data
spi_sdo_en_o  output  1  sdo output enable (high while selected)
rx_data_o  output  8  received byte
rx_valid_o  output  1  rx holding register full
rx_ready_i  input  1  consumer pops rx byte
rx_overflow_o  output  1  1-cycle pulse: completed byte dropped
tx_data_i  input  8  byte to transmit
tx_valid_i  input  1  tx byte offered
tx_ready_o  output  1  tx holding register empty
tx_underflow_o  output  1  1-cycle pulse: TxFill substituted
active_o  output  1  synchronised csb asserted (engine in SHIFT)

Behaviour:
- Reset values: spi_sdo_o=0, spi_sdo_en_o=0, rx_data_o=0, rx_valid_o=0, rx_overflow_o=0, tx_ready_o=1, tx_underflow_o=0, active_o=0. rst_i mid-transfer aborts immediately: partial byte lost, both holding registers emptied, FSM to IDLE.
- Inputs pass SyncStages flops; sck edges detected from last two synced samples. Host sck frequency is required to be <= f_clk/8. Sdo changes SyncStages+1 cycles after the host's shift edge.
- Leading edge = rising if cpol_i=0, else falling. Sample edge = leading if cpha_i=0, else trailing; shift edge = the other one. MSB first.
- FSM IDLE: csb high, sdo_en=0, bit_cnt=0. On synced csb fall -> LOAD.
- LOAD (1 cycle): shift_tx <= tx holding reg if full (empties it), else TxFill with tx_underflow_o pulse. spi_sdo_o <= bit7, sdo_en=1 -> SHIFT.
- SHIFT, on sample edge: shift_rx <= {shift_rx[6:0], sdi}; bit_cnt++.
  - At the 8th sample, bit_cnt wraps to 0 and the byte completes.
  - rx empty, or rx_ready_i popping the same cycle: byte written, rx_valid_o=1 next cycle.
  - rx full and not popping: new byte dropped, old byte kept, rx_overflow_o pulses.
- SHIFT, on shift edge:
  - bit_cnt!=0: drive next tx bit.
  - bit_cnt==0, i.e. after a completed byte (excludes the first trailing edge when cpha=1, which drives bit7 again): reload shift_tx as in LOAD and drive its bit7.
- SHIFT, synced csb rise (any bit_cnt) -> IDLE:
  - partial byte discarded;
  - sdo_en=0 and sdo=0 the next cycle;
  - holding registers retain contents.
- Tx holding reg: written when tx_valid_i && tx_ready_o. A write and an engine read in the same cycle leave it full with the new byte.
- Rx pop: rx_valid_o && rx_ready_i clears it unless a byte completes the same cycle.
- csb edge and sck edge in the same cycle: csb takes priority.

Optional Feature:
SPI_DEV_BYTE_ENGINE_DEBUG_EN:
- Defined: adds output sck_pulses_o [15:0], the count of sample edges since the last csb fall. It is cleared in LOAD, saturates at 16'hFFFF and is held after csb rise, mirroring the agent's sck_pulses debug signal.
- Undefined: the port and its counter are absent.

Decomposition:
- spi_dev_pkg holds: state_e {StIdle, StLoad, StShift}; ByteW=8; default TxFill constant.
- One sub-module, spi_dev_sck_edge: synchroniser plus sck rise/fall detection and cpol/cpha decode to sample_o/shift_o pulses; csb synchronised and edge-detected alongside.

Test Plan:
- Mode 0, tx 8'h3C preloaded, host sends 8'hA5 -> rx_data_o=8'hA5, rx_valid_o=1; host captures 8'h3C; tx_ready_o=1 after LOAD.
- Mode 3, host sends two bytes 8'h12,8'h34, tx bytes 8'hC0 then 8'hDE, rx_ready_i held 1 -> rx sequence 12,34; host sees C0,DE.
- No tx byte loaded, mode 1 -> host reads 8'hFF; tx_underflow_o pulses once per byte.
- rx_ready_i=0 for three host bytes 01,02,03 -> rx_data_o=01, two rx_overflow_o pulses; pop then yields empty.
- csb rises after 5 bits -> no rx_valid_o; next transfer of 8'h5A is received intact with bit alignment restored.
- rst_i asserted mid-byte then released -> all outputs at reset values; the next full transfer works correctly.
